// File: rtl/top_main_pkg.sv
// rtl/top_main_pkg.sv - opcode encoding and default widths for the top_main datapath
package top_main_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_MEM_AW = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOADI = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_ADD   = 4'd4,
    OP_SUB   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_NOT   = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_ADDM  = 4'd12,
    OP_MEMWR = 4'd13
  } opcode_e;

endpackage

// File: rtl/top_main_if.sv
// rtl/top_main_if.sv - signal bundle for driving top_main, clocked by clk
interface top_main_if
  import top_main_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input logic clk
);

  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        opcode;
  logic [MEM_AW-1:0] read_address;
  logic [MEM_AW-1:0] write_address;
  logic [REG_AW-1:0] read_address_reg;
  logic [REG_AW-1:0] write_address_reg;
  logic [REG_AW-1:0] reg1;
  logic [REG_AW-1:0] reg2;
  logic [REG_AW-1:0] address_alu;
  logic [MEM_AW-1:0] address_to_mem;
  logic [MEM_AW-1:0] address_mem;
  logic [DATA_W-1:0] data_out_mem;
  logic              zero;

endinterface

// File: rtl/top_main_alu.sv
// rtl/top_main_alu.sv - combinational ALU; result wraps modulo 2^DATA_W
module top_main_alu
  import top_main_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              is_zero
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD, OP_ADDM: result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_NOT:          result = ~a;
      OP_SHL:          result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:          result = {1'b0, a[DATA_W-1:1]};
      default:         result = '0;
    endcase
  end

  assign is_zero = (result == '0);

endmodule

// File: rtl/top_main.sv
// rtl/top_main.sv - single-cycle datapath: 8-entry register file, 16-word memory, ALU
module top_main
  import top_main_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        opcode,
  input  logic [MEM_AW-1:0] read_address,
  input  logic [MEM_AW-1:0] write_address,
  input  logic [REG_AW-1:0] read_address_reg,
  input  logic [REG_AW-1:0] write_address_reg,
  input  logic [REG_AW-1:0] reg1,
  input  logic [REG_AW-1:0] reg2,
  input  logic [REG_AW-1:0] address_alu,
  input  logic [MEM_AW-1:0] address_to_mem,
  input  logic [MEM_AW-1:0] address_mem,
  output logic [DATA_W-1:0] data_out_mem,
  output logic              zero
);

  localparam int NREG = 2 ** REG_AW;
  localparam int NMEM = 2 ** MEM_AW;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] mem  [NMEM];
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_op;

  top_main_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (regs[reg1]),
    .b       (regs[reg2]),
    .opcode  (opcode),
    .result  (alu_result),
    .is_zero (alu_zero)
  );

  // ADDM counts as an ALU op for the zero flag even though it writes memory
  assign alu_op = (opcode >= OP_ADD) && (opcode <= OP_ADDM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < NMEM; i++) mem[i] <= '0;
      data_out_mem <= '0;
      zero         <= 1'b0;
    end else begin
      data_out_mem <= mem[address_mem];
      if (alu_op) zero <= alu_zero;
      case (opcode)
        OP_LOADI: regs[write_address_reg] <= data_in;
        OP_LOAD:  regs[write_address_reg] <= mem[read_address];
        OP_STORE: mem[write_address]      <= regs[read_address_reg];
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR:
                  regs[address_alu]       <= alu_result;
        OP_ADDM:  mem[address_to_mem]     <= alu_result;
        OP_MEMWR: mem[write_address]      <= data_in;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_main.sv
// tb/tb_top_main.sv - self-checking bench for top_main
module tb_top_main;
  import top_main_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  top_main_if bus (.clk(clk));

  top_main dut (
    .clk               (clk),
    .rst               (bus.rst),
    .data_in           (bus.data_in),
    .opcode            (bus.opcode),
    .read_address      (bus.read_address),
    .write_address     (bus.write_address),
    .read_address_reg  (bus.read_address_reg),
    .write_address_reg (bus.write_address_reg),
    .reg1              (bus.reg1),
    .reg2              (bus.reg2),
    .address_alu       (bus.address_alu),
    .address_to_mem    (bus.address_to_mem),
    .address_mem       (bus.address_mem),
    .data_out_mem      (bus.data_out_mem),
    .zero              (bus.zero)
  );

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [3:0] ma;
    logic [3:0] obs;
    logic [7:0] data;
    logic [7:0] exp_dout;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   m_regs[8];
  int   m_mem[16];
  int   m_zero;
  int   m_dout;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] r1,
                     input logic [2:0] r2, input logic [3:0] ma, input logic [3:0] obs,
                     input logic [7:0] data, input logic [7:0] exp_dout, input logic exp_zero);
    vec_t v;
    v.op = op; v.rd = rd; v.r1 = r1; v.r2 = r2; v.ma = ma; v.obs = obs;
    v.data = data; v.exp_dout = exp_dout; v.exp_zero = exp_zero;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] war, input logic [2:0] rar,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] aalu,
                       input logic [3:0] ra, input logic [3:0] wa, input logic [3:0] atm,
                       input logic [3:0] am, input logic [7:0] data);
    bus.opcode = op; bus.write_address_reg = war; bus.read_address_reg = rar;
    bus.reg1 = r1; bus.reg2 = r2; bus.address_alu = aalu;
    bus.read_address = ra; bus.write_address = wa; bus.address_to_mem = atm;
    bus.address_mem = am; bus.data_in = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_zero = 0;
    m_dout = 0;
  endtask

  // Reference: one opcode applied to array state, operands taken before any write
  task automatic model_step();
    int a, b, res;
    bit alu;
    a = m_regs[bus.reg1];
    b = m_regs[bus.reg2];
    alu = 1'b1;
    res = 0;
    case (int'(bus.opcode))
      4, 12: res = a + b;
      5:     res = a - b;
      6:     res = a & b;
      7:     res = a | b;
      8:     res = a ^ b;
      9:     res = 255 - a;
      10:    res = a * 2;
      11:    res = a / 2;
      default: alu = 1'b0;
    endcase
    res = res & 255;
    m_dout = m_mem[bus.address_mem];
    if (alu) m_zero = (res == 0) ? 1 : 0;
    case (int'(bus.opcode))
      1:  m_regs[bus.write_address_reg] = int'(bus.data_in);
      2:  m_regs[bus.write_address_reg] = m_mem[bus.read_address];
      3:  m_mem[bus.write_address] = m_regs[bus.read_address_reg];
      4, 5, 6, 7, 8, 9, 10, 11: m_regs[bus.address_alu] = res;
      12: m_mem[bus.address_to_mem] = res;
      13: m_mem[bus.write_address] = int'(bus.data_in);
      default: ;
    endcase
  endtask

  initial begin
    bus.rst = 1'b1;
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    #12;
    check("reset_dout", bus.data_out_mem, 8'h00);
    check("reset_zero", {7'd0, bus.zero}, 8'h00);
    bus.rst = 1'b0;

    // Scripted program: rd/ma feed every register/memory address port at once
    add(OP_LOADI, 2, 0, 0, 0, 7, 8'h3C, 8'h00, 0);
    add(OP_STORE, 2, 0, 0, 7, 7, 8'h00, 8'h00, 0);
    add(OP_NOP,   0, 0, 0, 0, 7, 8'h00, 8'h3C, 0);
    add(OP_LOADI, 0, 0, 0, 0, 7, 8'h05, 8'h3C, 0);
    add(OP_LOADI, 1, 0, 0, 0, 7, 8'h05, 8'h3C, 0);
    add(OP_SUB,   3, 0, 1, 0, 7, 8'h00, 8'h3C, 1);
    add(OP_STORE, 3, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(OP_LOADI, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 1);
    add(OP_LOADI, 1, 0, 0, 0, 0, 8'h01, 8'h00, 1);
    add(OP_ADD,   4, 0, 1, 0, 0, 8'h00, 8'h00, 1);
    add(OP_LOADI, 0, 0, 0, 0, 0, 8'h05, 8'h00, 1);
    add(OP_OR,    5, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(OP_STORE, 5, 0, 0, 1, 1, 8'h00, 8'h00, 0);
    add(OP_NOP,   0, 0, 0, 0, 1, 8'h00, 8'h05, 0);
    add(OP_LOADI, 0, 0, 0, 0, 1, 8'h81, 8'h05, 0);
    add(OP_SHL,   6, 0, 0, 0, 2, 8'h00, 8'h00, 0);
    add(OP_STORE, 6, 0, 0, 2, 2, 8'h00, 8'h00, 0);
    add(OP_SHR,   6, 0, 0, 0, 2, 8'h00, 8'h02, 0);
    add(OP_STORE, 6, 0, 0, 2, 2, 8'h00, 8'h02, 0);
    add(OP_NOT,   6, 0, 0, 0, 2, 8'h00, 8'h40, 0);
    add(OP_STORE, 6, 0, 0, 2, 2, 8'h00, 8'h40, 0);
    add(OP_NOP,   0, 0, 0, 0, 2, 8'h00, 8'h7E, 0);
    add(OP_SUB,   7, 0, 0, 0, 2, 8'h00, 8'h7E, 1);
    add(OP_LOADI, 7, 0, 0, 0, 2, 8'hAA, 8'h7E, 1);
    add(OP_MEMWR, 0, 0, 0, 3, 3, 8'hA5, 8'h00, 1);
    add(OP_LOAD,  6, 0, 0, 3, 3, 8'h00, 8'hA5, 1);
    add(OP_STORE, 6, 0, 0, 4, 4, 8'h00, 8'h00, 1);
    add(OP_NOP,   0, 0, 0, 0, 4, 8'h00, 8'hA5, 1);
    add(OP_LOADI, 0, 0, 0, 0, 9, 8'h10, 8'h00, 1);
    add(OP_LOADI, 1, 0, 0, 0, 9, 8'h20, 8'h00, 1);
    add(OP_ADDM,  0, 0, 1, 9, 9, 8'h00, 8'h00, 0);
    add(OP_NOP,   0, 0, 0, 0, 9, 8'h00, 8'h30, 0);
    add(OP_MEMWR, 0, 0, 0, 5, 5, 8'h77, 8'h00, 0);
    add(OP_STORE, 4, 0, 0, 5, 5, 8'h00, 8'h77, 0);
    add(OP_NOP,   0, 0, 0, 0, 5, 8'h00, 8'h00, 0);
    add(4'd14,    2, 0, 0, 9, 9, 8'hFF, 8'h30, 0);
    add(4'd15,    2, 0, 0, 9, 9, 8'hFF, 8'h30, 0);
    add(OP_NOP,   0, 0, 0, 0, 9, 8'h00, 8'h30, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].rd,
            vecs[i].ma, vecs[i].ma, vecs[i].ma, vecs[i].obs, vecs[i].data);
      step();
      check($sformatf("vec%0d_dout", i), bus.data_out_mem, vecs[i].exp_dout);
      check($sformatf("vec%0d_zero", i), {7'd0, bus.zero}, {7'd0, vecs[i].exp_zero});
    end

    // Async reset between edges, with zero=1 and a nonzero observed word beforehand
    drive(OP_SUB, 0, 0, 0, 0, 7, 0, 0, 0, 9, 8'h00);
    step();
    check("pre_rst_zero", {7'd0, bus.zero}, 8'h01);
    #2;
    bus.rst = 1'b1;
    #1;
    check("async_rst_dout", bus.data_out_mem, 8'h00);
    check("async_rst_zero", {7'd0, bus.zero}, 8'h00);
    #2;
    bus.rst = 1'b0;
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 5, 8'h00);
    step();
    check("post_rst_mem5", bus.data_out_mem, 8'h00);
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8'h00);
    step();
    check("post_rst_mem9", bus.data_out_mem, 8'h00);

    model_reset();
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 8'($urandom));
      model_step();
      step();
      check($sformatf("rand%0d_dout", n), bus.data_out_mem, 8'(m_dout));
      check($sformatf("rand%0d_zero", n), {7'd0, bus.zero}, 8'(m_zero));
    end

    // Reset held across a LOADI edge: the write must be lost and memory cleared
    drive(OP_LOADI, 2, 2, 0, 0, 0, 0, 0, 0, 0, 8'h5A);
    @(negedge clk);
    bus.rst = 1'b1;
    step();
    bus.rst = 1'b0;
    drive(OP_STORE, 2, 2, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    step();
    check("midrst_store_edge", bus.data_out_mem, 8'h00);
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    step();
    check("midrst_r2", bus.data_out_mem, 8'h00);
    check("midrst_zero", {7'd0, bus.zero}, 8'h00);
    for (int i = 1; i < 16; i++) begin
      drive(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 4'(i), 8'h00);
      step();
      check($sformatf("midrst_mem%0d", i), bus.data_out_mem, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
